vram_arbiter: RTL

- Shares the single-port character/attribute VRAM between the display fetch path and the CPU bus interface.
- The display read port has absolute priority and a fixed latency, so pixel timing is never disturbed.
- CPU reads and writes use a req/ack handshake and are slotted into cycles where the display is not fetching.
- Sits between the display module's VRAM address output, the Z80 memory decoder and the VRAM block RAM.

---
 rtl/vram_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: the display fetch path has absolute priority with a fixed
// two-edge latency; the CPU gets the leftover cycles. Option macro: VRAM_BLANK_ACCESS_EN.
module vram_arbiter #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 15
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_disp_req,
  input  logic [ADDR_W-1:0] i_disp_addr,
  output logic [DATA_W-1:0] o_disp_data,
  output logic              o_disp_valid,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_ack,
  output logic [DATA_W-1:0] o_cpu_rdata,
  input  logic              i_blank,
  output logic              o_cpu_starved,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    C_IDLE  = 3'd0,
    C_WR    = 3'd1,
    C_RD    = 3'd2,
    C_RDATA = 3'd3,
    C_DONE  = 3'd4
  } cpu_state_t;

  cpu_state_t        state_q;
  logic              disp_p1_q, disp_p2_q;
  logic [CNT_W-1:0]  wait_q;
  logic [DATA_W-1:0] disp_data_q, cpu_rdata_q, ram_wdata_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic              disp_valid_q, cpu_ack_q, starved_q, ram_en_q, ram_we_q;
  logic              blank_ok, cpu_grant, cpu_waiting;

`ifdef VRAM_BLANK_ACCESS_EN
  // CPU accesses confined to blanking, mimicking the original snow-free timing.
  assign blank_ok = i_blank;
`else
  logic unused_blank;
  assign unused_blank = i_blank;
  assign blank_ok     = 1'b1;
`endif

  assign cpu_grant   = (state_q == C_IDLE) && i_cpu_req && !i_disp_req && blank_ok;
  assign cpu_waiting = (state_q == C_IDLE) && i_cpu_req && !cpu_grant;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= C_IDLE;
      disp_p1_q    <= 1'b0;
      disp_p2_q    <= 1'b0;
      wait_q       <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
      starved_q    <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
    end else begin
      ram_en_q  <= 1'b0;
      ram_we_q  <= 1'b0;
      cpu_ack_q <= 1'b0;

      // Display pipeline: port at k, RAM capture at k+1, data register at k+2.
      disp_p1_q    <= i_disp_req;
      disp_p2_q    <= disp_p1_q;
      disp_valid_q <= disp_p2_q;
      if (disp_p2_q) disp_data_q <= i_ram_rdata;

      if (i_disp_req) begin
        ram_en_q   <= 1'b1;
        ram_addr_q <= i_disp_addr;
      end

      case (state_q)
        C_IDLE: begin
          if (cpu_grant) begin
            ram_en_q    <= 1'b1;
            ram_we_q    <= i_cpu_we;
            ram_addr_q  <= i_cpu_addr;
            ram_wdata_q <= i_cpu_wdata;
            state_q     <= i_cpu_we ? C_WR : C_RD;
          end
        end
        C_WR: begin
          cpu_ack_q <= 1'b1;
          state_q   <= C_DONE;
        end
        C_RD:    state_q <= C_RDATA;
        C_RDATA: begin
          cpu_rdata_q <= i_ram_rdata;
          cpu_ack_q   <= 1'b1;
          state_q     <= C_DONE;
        end
        C_DONE:  state_q <= C_IDLE;
        default: state_q <= C_IDLE;
      endcase

      // Starvation: saturating count of refused idle-state requests; flag is sticky.
      if (cpu_grant) begin
        wait_q <= '0;
      end else if (cpu_waiting && (wait_q < CNT_W'(MAX_WAIT))) begin
        wait_q <= wait_q + 1'b1;
        if (wait_q == CNT_W'(MAX_WAIT - 1)) starved_q <= 1'b1;
      end
    end
  end

  assign o_disp_data   = disp_data_q;
  assign o_disp_valid  = disp_valid_q;
  assign o_cpu_ack     = cpu_ack_q;
  assign o_cpu_rdata   = cpu_rdata_q;
  assign o_cpu_starved = starved_q;
  assign o_ram_en      = ram_en_q;
  assign o_ram_we      = ram_we_q;
  assign o_ram_addr    = ram_addr_q;
  assign o_ram_wdata   = ram_wdata_q;

endmodule
